// File: rtl/credit_return_generator_pkg.sv
// -----------------------------------------------------------------------------
// credit_return_generator_pkg
//   Shared definitions for the credit return generator:
//     - state_e       : FSM state encoding (IDLE / ISSUE / HOLDOFF)
//     - clog2_min1()  : ceil(log2(n)), never below 1, for sizing counters
//                       whose natural width could collapse to zero bits
//                       (e.g. the gap counter when GAP = 0).
// -----------------------------------------------------------------------------
package credit_return_generator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : credit_return_generator_pkg

// File: rtl/credit_return_generator_if.sv
// -----------------------------------------------------------------------------
// credit_return_generator_if
//   One-credit valid/ready return channel between the receiver (credit
//   source) and the sender's credit counter (credit sink).
//     credit_valid : a credit is offered         (master -> slave)
//     credit_ready : the sender accepts it       (slave  -> master)
//   A transfer is credit_valid && credit_ready at a rising clock edge and
//   moves exactly one credit.
// -----------------------------------------------------------------------------
interface credit_return_generator_if;

  logic credit_valid;
  logic credit_ready;

  modport master (
    output credit_valid,
    input  credit_ready
  );

  modport slave (
    input  credit_valid,
    output credit_ready
  );

endinterface : credit_return_generator_if

// File: rtl/credit_return_generator_pending.sv
// -----------------------------------------------------------------------------
// credit_return_generator_pending
//   Up/down counter of credits owed to the sender, saturating at MAX and
//   floored at 0. Synchronous active-high reset reloads MAX, which is the
//   full initial allotment the receiver owes after reset.
//
//   Ports:
//     clock   : rising-edge clock
//     reset   : synchronous, active-high; loads count to MAX
//     inc     : one slot freed this cycle
//     dec     : one credit transferred this cycle
//     count_q : registered count
//     count_d : next-cycle count (used by the FSM to look ahead)
// -----------------------------------------------------------------------------
module credit_return_generator_pending #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count_q,
  output logic [W-1:0] count_d
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      // Saturate: a slot freed while the full allotment is already owed is
      // dropped rather than wrapping.
      if (count_q != MAX_V) count_d = count_q + W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) count_q <= MAX_V;
    else       count_q <= count_d;
  end

endmodule : credit_return_generator_pending

// File: rtl/credit_return_generator.sv
// -----------------------------------------------------------------------------
// credit_return_generator
//   Receiver-side companion to a sender's saturating credit counter. Counts
//   freed buffer slots and returns them one at a time over a valid/ready
//   channel. After reset the full allotment of CREDITS is owed, so the
//   sender's counter fills from 0 to CREDITS. GAP forces idle cycles after
//   each accepted credit for slow or clock-gated sender logic.
//
//   Parameters:
//     CREDITS      : receiver buffer slots / credits in circulation (>= 1)
//     CREDITS_LOG2 : width of pending
//     GAP          : idle cycles with credit_valid low after each transfer
//
//   Ports:
//     clock      : rising-edge clock
//     reset      : synchronous, active-high
//     slot_freed : one-cycle pulse, one buffer slot released
//     credit     : return channel (master side: credit_valid out,
//                  credit_ready in)
//     pending    : credits owed and not yet transferred
//     overflow   : sticky error, slot freed while pending == CREDITS with
//                  no transfer in the same cycle
//
//   Build option:
//     CREDIT_RETURN_GENERATOR_OVERFLOW_CHECK_EN
//       defined   : overflow is a registered sticky flag, cleared by reset
//       undefined : overflow is tied to 0 and no check logic exists
// -----------------------------------------------------------------------------
module credit_return_generator
  import credit_return_generator_pkg::*;
#(
  parameter int CREDITS      = 4,
  parameter int CREDITS_LOG2 = $clog2(CREDITS + 1),
  parameter int GAP          = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          slot_freed,
  credit_return_generator_if.master     credit,
  output logic [CREDITS_LOG2-1:0]       pending,
  output logic                          overflow
);

  localparam int GAP_W = clog2_min1(GAP + 1);

  state_e                  state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [CREDITS_LOG2-1:0] pending_q, pending_d;
  logic                    transfer;

  // Reset withdraws an offered credit in the same cycle; the sender's
  // counter is reset alongside, so nothing may be transferred meanwhile.
  assign credit.credit_valid = (state_q == ISSUE) && !reset;
  assign transfer            = credit.credit_valid && credit.credit_ready;
  assign pending             = pending_q;

  credit_return_generator_pending #(
    .MAX (CREDITS),
    .W   (CREDITS_LOG2)
  ) u_pending (
    .clock   (clock),
    .reset   (reset),
    .inc     (slot_freed),
    .dec     (transfer),
    .count_q (pending_q),
    .count_d (pending_d)
  );

  // Next-state logic looks at pending_d so a credit freed this cycle is
  // offered next cycle, and the last credit's transfer drops valid at once.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (pending_d != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (transfer) begin
          if (GAP > 0) begin
            state_d = HOLDOFF;
            gap_d   = GAP_W'(GAP - 1);
          end else if (pending_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        if (gap_q == '0) state_d = (pending_d != '0) ? ISSUE : IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ISSUE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

`ifdef CREDIT_RETURN_GENERATOR_OVERFLOW_CHECK_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (slot_freed && !transfer && (pending_q == CREDITS_LOG2'(CREDITS)))
      overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule : credit_return_generator

// File: tb/tb_credit_return_generator.sv
// -----------------------------------------------------------------------------
// tb_credit_return_generator
//   dut0: CREDITS=4, GAP=0, driven from a vector table.
//   dut1: CREDITS=4, GAP=3, hand-written spacing sequence.
// -----------------------------------------------------------------------------
module tb_credit_return_generator;

  logic clk;
  logic rst0, rst1;
  logic sf0, sf1;
  logic [2:0] pend0, pend1;
  logic ovf0, ovf1;

  int checks = 0;
  int errors = 0;

`ifdef CREDIT_RETURN_GENERATOR_OVERFLOW_CHECK_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  credit_return_generator_if crif0();
  credit_return_generator_if crif1();

  credit_return_generator #(.CREDITS(4), .GAP(0)) dut0 (
    .clock      (clk),
    .reset      (rst0),
    .slot_freed (sf0),
    .credit     (crif0.master),
    .pending    (pend0),
    .overflow   (ovf0)
  );

  credit_return_generator #(.CREDITS(4), .GAP(3)) dut1 (
    .clock      (clk),
    .reset      (rst1),
    .slot_freed (sf1),
    .credit     (crif1.master),
    .pending    (pend1),
    .overflow   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs for the cycle, and outputs expected during that cycle (before
  // the next rising edge).
  typedef struct {
    logic       rst;
    logic       sf;
    logic       rdy;
    logic       valid;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sf, input logic rdy,
                     input logic valid, input logic [2:0] pend, input logic ovf);
    vec_t v;
    v.rst = rst; v.sf = sf; v.rdy = rdy;
    v.valid = valid; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    rst0 = 1'b1; sf0 = 1'b0; crif0.credit_ready = 1'b0;
    rst1 = 1'b1; sf1 = 1'b0; crif1.credit_ready = 1'b0;

    //  rst sf rdy | valid pend ovf
    add(1, 0, 1,   0, 4, 0);    // reset held: valid withdrawn, pending loaded
    add(0, 0, 1,   1, 4, 0);    // initial allotment drains 4,3,2,1
    add(0, 0, 1,   1, 3, 0);
    add(0, 0, 1,   1, 2, 0);
    add(0, 0, 1,   1, 1, 0);
    add(0, 0, 1,   0, 0, 0);    // IDLE, ready ignored
    add(0, 1, 1,   0, 0, 0);    // slot freed in IDLE
    add(0, 0, 1,   1, 1, 0);    // valid next cycle, transfer
    add(0, 0, 0,   0, 0, 0);
    add(0, 1, 0,   0, 0, 0);    // build pending = 2 under back-pressure
    add(0, 1, 0,   1, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 2, 0);   // valid held stable
    add(0, 0, 1,   1, 2, 0);    // two back-to-back transfers
    add(0, 0, 1,   1, 1, 0);
    add(0, 0, 1,   0, 0, 0);
    add(0, 1, 0,   0, 0, 0);    // pending -> 1
    add(0, 1, 1,   1, 1, 0);    // free + transfer together: unchanged
    add(0, 0, 0,   1, 1, 0);
    add(0, 1, 0,   1, 1, 0);    // fill to 4
    add(0, 1, 0,   1, 2, 0);
    add(0, 1, 0,   1, 3, 0);
    add(0, 1, 0,   1, 4, 0);    // overflow: freed at full, no transfer
    add(0, 0, 0,   1, 4, OVF);  // saturated, flag set
    add(0, 0, 0,   1, 4, OVF);  // sticky
    add(0, 1, 1,   1, 4, OVF);  // freed with transfer at full: not overflow
    add(0, 0, 1,   1, 4, OVF);  // transfer -> 3
    add(1, 0, 1,   0, 3, OVF);  // reset mid-transfer: valid withdrawn now
    add(0, 0, 0,   1, 4, 0);    // reloaded allotment, flag cleared
    add(0, 0, 0,   1, 4, 0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst0 = vecs[i].rst;
      sf0  = vecs[i].sf;
      crif0.credit_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d.valid", i),    32'(crif0.credit_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d.pending", i),  32'(pend0),              32'(vecs[i].pend));
      check($sformatf("v%0d.overflow", i), 32'(ovf0),               32'(vecs[i].ovf));
    end

    // GAP=3: transfers exactly 4 cycles apart, valid low 3 cycles between.
    @(negedge clk);
    rst0 = 1'b1; sf0 = 1'b0; crif0.credit_ready = 1'b0;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    crif1.credit_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      logic       ev;
      logic [2:0] ep;
      ev = (c < 16) && (c % 4 == 0);
      ep = (c >= 13) ? 3'd0 : 3'(4 - (c + 3) / 4);
      #1;
      check($sformatf("gap.c%0d.valid", c),   32'(crif1.credit_valid), 32'(ev));
      check($sformatf("gap.c%0d.pending", c), 32'(pend1),              32'(ep));
      @(negedge clk);
    end

    // slot freed during HOLDOFF is counted and issued after the gap.
    sf1 = 1'b1;           // cycle A: IDLE, pending 0
    #1;
    check("gap.idle_free.valid", 32'(crif1.credit_valid), 32'(0));
    @(negedge clk);
    sf1 = 1'b0;           // cycle B: ISSUE with pending 1, transfer
    #1;
    check("gap.reissue.valid",   32'(crif1.credit_valid), 32'(1));
    check("gap.reissue.pending", 32'(pend1),              32'(1));
    @(negedge clk);
    sf1 = 1'b1;           // HOLDOFF cycle 1: free counted
    #1;
    check("gap.hold.valid", 32'(crif1.credit_valid), 32'(0));
    @(negedge clk);
    sf1 = 1'b0;
    @(negedge clk);       // HOLDOFF cycle 3
    #1;
    check("gap.hold3.valid",   32'(crif1.credit_valid), 32'(0));
    check("gap.hold3.pending", 32'(pend1),              32'(1));
    @(negedge clk);
    #1;
    check("gap.after.valid", 32'(crif1.credit_valid), 32'(1));
    check("gap.after.overflow", 32'(ovf1), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_credit_return_generator
